// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline boundary register with flush, bubble and perf counters
module pipe_stage_reg #(
    parameter int STAGE   = 3,
    parameter int STALL_W = 6,
    parameter int NLANES  = 1,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     cnt_clr,
    input  logic                     in_valid,
    input  logic [NLANES*ADDR_W-1:0] in_wd,
    input  logic [NLANES-1:0]        in_wreg,
    input  logic [NLANES*DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic [DATA_W-1:0]        in_lo,
    input  logic                     in_whilo,
    output logic                     out_valid,
    output logic [NLANES*ADDR_W-1:0] out_wd,
    output logic [NLANES-1:0]        out_wreg,
    output logic [NLANES*DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0]        out_hi,
    output logic [DATA_W-1:0]        out_lo,
    output logic                     out_whilo,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Only our own stage bit and the downstream bit matter; the rest of the
    // vector belongs to other boundaries.
    logic s_up;
    logic s_dn;
    logic stall_unused;

    assign s_up         = stall[STAGE];
    assign s_dn         = stall[STAGE+1];
    assign stall_unused = ^stall;

    logic do_bubble;
    logic do_advance;
    logic inc_stall;
    logic inc_bubble;

    // Decode the single per-cycle action; flush wins over any stall combination
    // and suppresses the counters for that cycle.
    always_comb begin
        do_bubble  = 1'b0;
        do_advance = 1'b0;
        inc_stall  = 1'b0;
        inc_bubble = 1'b0;
        if (flush) begin
            do_bubble = 1'b1;
        end else if (s_up && !s_dn) begin
            do_bubble  = 1'b1;
            inc_stall  = 1'b1;
            inc_bubble = 1'b1;
        end else if (s_up && s_dn) begin
            inc_stall = 1'b1;
        end else begin
            // s_up=0 advances even when s_dn=1 (illegal from ctrl, tolerated here)
            do_advance = 1'b1;
        end
    end

    // Payload register: a bubble zeroes every field, including the write
    // enables, so it can never retire a GPR or HI/LO write; hold keeps all.
    always_ff @(posedge clk) begin
        if (rst || do_bubble) begin
            out_valid <= 1'b0;
            out_wd    <= '0;
            out_wreg  <= '0;
            out_wdata <= '0;
            out_hi    <= '0;
            out_lo    <= '0;
            out_whilo <= 1'b0;
        end else if (do_advance) begin
            out_valid <= in_valid;
            out_wd    <= in_wd;
            out_wreg  <= in_wreg;
            out_wdata <= in_wdata;
            out_hi    <= in_hi;
            out_lo    <= in_lo;
            out_whilo <= in_whilo;
        end
    end

    // Saturating performance counters; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (inc_stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (inc_bubble && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule
